// File: rtl/tlk2711_rd_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module  : tlk2711_rd_cmd_arb
// Brief   : Round-robin arbiter sharing one DMA read-command port among
//           CH_NUM TLK2711 TX channels, one command outstanding at a time.
// Revision: 1.0 - initial release
// ============================================================================
module tlk2711_rd_cmd_arb #(
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = 48,
  parameter int DLEN_WIDTH  = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_soft_rst,
  input  logic [CH_NUM-1:0]                     i_ch_en,
  input  logic [CH_NUM-1:0]                     i_ch_cmd_req,
  input  logic [CH_NUM*(DLEN_WIDTH+ADDR_WIDTH)-1:0] i_ch_cmd_data,
  output logic [CH_NUM-1:0]                     o_ch_cmd_ack,
  output logic [CH_NUM-1:0]                     o_ch_done,
  output logic [CH_NUM-1:0]                     o_ch_sel,
  output logic                                  o_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]      o_cmd_data,
  input  logic                                  i_cmd_ack,
  input  logic                                  i_done,
  output logic                                  o_timeout,
  output logic [31:0]                           o_cmd_cnt
);

  localparam int          CW        = DLEN_WIDTH + ADDR_WIDTH;
  localparam int          PW        = $clog2(CH_NUM);
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gidx;
  logic [CH_NUM-1:0]   r_ch_sel;
  logic [CW-1:0]       r_cmd_data;
  logic [31:0]         r_cmd_cnt;
  logic [31:0]         r_wd;

  logic [CH_NUM-1:0]   w_elig;
  logic [CH_NUM-1:0]   w_gnt;
  logic [2*CH_NUM-1:0] w_dbl;
  logic [PW:0]         w_sum;
  logic [PW-1:0]       w_gidx;
  logic                w_found;
  logic [CW-1:0]       w_word;
  logic [PW-1:0]       w_ptr_nxt;
  logic                w_to;

  // Rotate eligibility by ptr; the lowest rotated offset wins, so iterate downward.
  always_comb begin
    w_elig  = i_ch_cmd_req & i_ch_en;
    w_dbl   = {w_elig, w_elig} >> r_ptr;
    w_found = 1'b0;
    w_gidx  = '0;
    w_gnt   = '0;
    w_sum   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_sum = {1'b0, r_ptr} + (PW+1)'(i);
        if (w_sum >= (PW+1)'(CH_NUM)) begin
          w_sum = w_sum - (PW+1)'(CH_NUM);
        end
        w_found = 1'b1;
        w_gidx  = w_sum[PW-1:0];
        w_gnt   = CH_NUM'(1) << w_sum;
      end
    end
    w_word = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (w_gnt[k]) begin
        w_word = w_word | i_ch_cmd_data[k*CW +: CW];
      end
    end
  end

  assign w_ptr_nxt = (r_gidx == PW'(CH_NUM - 1)) ? '0 : r_gidx + PW'(1);

  // A done in the same cycle as the watchdog expiry wins over the timeout.
  assign w_to = (TIMEOUT_CYC != 0) && (r_state == ST_WAIT) && (r_wd == c_TO_LAST)
                && !i_done && !i_soft_rst;

  assign o_cmd_req    = (r_state == ST_ISSUE);
  assign o_cmd_data   = r_cmd_data;
  assign o_ch_sel     = r_ch_sel;
  assign o_cmd_cnt    = r_cmd_cnt;
  assign o_timeout    = w_to;
  assign o_ch_cmd_ack = ((r_state == ST_ISSUE) && i_cmd_ack && !i_soft_rst) ? r_ch_sel : '0;
  assign o_ch_done    = ((r_state == ST_WAIT) && i_done && !i_soft_rst) ? r_ch_sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_ch_sel   <= '0;
      r_cmd_data <= '0;
      r_cmd_cnt  <= '0;
      r_wd       <= '0;
    end else if (i_soft_rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_ch_sel <= '0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_cmd_data <= w_word;
            r_ch_sel   <= w_gnt;
            r_gidx     <= w_gidx;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_cmd_ack) begin
            r_state   <= ST_WAIT;
            r_ptr     <= w_ptr_nxt;
            r_cmd_cnt <= r_cmd_cnt + 32'd1;
            r_wd      <= '0;
          end
        end
        ST_WAIT: begin
          if (i_done || w_to) begin
            r_state  <= ST_IDLE;
            r_ch_sel <= '0;
          end else begin
            r_wd <= r_wd + 32'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ch_sel <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_rd_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlk2711_rd_cmd_arb
// Brief   : Directed scoreboard bench for the DMA read-command arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tlk2711_rd_cmd_arb;

  localparam int CH = 4;
  localparam int CW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_soft_rst = 1'b0;
  logic [CH-1:0]   i_ch_en = '0;
  logic [CH-1:0]   i_ch_cmd_req = '0;
  logic [CH*CW-1:0] i_ch_cmd_data;
  logic [CH-1:0]   o_ch_cmd_ack;
  logic [CH-1:0]   o_ch_done;
  logic [CH-1:0]   o_ch_sel;
  logic            o_cmd_req;
  logic [CW-1:0]   o_cmd_data;
  logic            i_cmd_ack = 1'b0;
  logic            i_done = 1'b0;
  logic            o_timeout;
  logic [31:0]     o_cmd_cnt;

  int checks = 0;
  int errors = 0;
  int exp_acc[$];
  logic [CH-1:0] exp_done[$];
  int exp_to[$];
  logic [CW-1:0] c_data [CH];
  int  mon_ch;
  bit  ok;

  tlk2711_rd_cmd_arb #(
    .CH_NUM(CH), .ADDR_WIDTH(48), .DLEN_WIDTH(16), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
    .i_ch_en(i_ch_en), .i_ch_cmd_req(i_ch_cmd_req), .i_ch_cmd_data(i_ch_cmd_data),
    .o_ch_cmd_ack(o_ch_cmd_ack), .o_ch_done(o_ch_done), .o_ch_sel(o_ch_sel),
    .o_cmd_req(o_cmd_req), .o_cmd_data(o_cmd_data), .i_cmd_ack(i_cmd_ack),
    .i_done(i_done), .o_timeout(o_timeout), .o_cmd_cnt(o_cmd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not as expected", name);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst && o_cmd_req && i_cmd_ack && !i_soft_rst) begin
      if (exp_acc.size() == 0) fail_now("acc_unexpected");
      else begin
        mon_ch = exp_acc.pop_front();
        chk("acc_sel", 64'(o_ch_sel), 64'(1 << mon_ch));
        chk("acc_ack", 64'(o_ch_cmd_ack), 64'(1 << mon_ch));
        chk("acc_data", o_cmd_data, c_data[mon_ch]);
      end
    end else if (o_ch_cmd_ack != '0) begin
      chk("stray_ack", 64'(o_ch_cmd_ack), 64'(0));
    end
    if (o_ch_done != '0) begin
      if (exp_done.size() == 0) chk("stray_done", 64'(o_ch_done), 64'(0));
      else chk("done", 64'(o_ch_done), 64'(exp_done.pop_front()));
    end
    if (o_timeout) begin
      if (exp_to.size() == 0) fail_now("stray_timeout");
      else void'(exp_to.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_cmd_req) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("req_wait_timeout");
  endtask

  // Request already raised by the caller; ack 2 cycles after o_cmd_req, done dn cycles after ack.
  task automatic txn(input int ch, input bit drop, input int dn);
    bit f;
    exp_acc.push_back(ch);
    wait_req(f);
    if (!f) return;
    repeat (2) tick();
    i_cmd_ack = 1'b1;
    tick();
    i_cmd_ack = 1'b0;
    if (drop) i_ch_cmd_req = '0;
    chk("sel_wait", 64'(o_ch_sel), 64'(1 << ch));
    repeat (dn - 1) tick();
    exp_done.push_back(CH'(1 << ch));
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("sel_clr", 64'(o_ch_sel), 64'(0));
  endtask

  task automatic ack_only(input int ch);
    bit f;
    exp_acc.push_back(ch);
    wait_req(f);
    repeat (2) tick();
    i_cmd_ack = 1'b1;
    tick();
    i_cmd_ack = 1'b0;
    i_ch_cmd_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    c_data[0] = 64'h0010_0000_0000_1000;
    c_data[1] = 64'h0020_0000_0000_2000;
    c_data[2] = 64'h0040_1234_5678_9ABC;
    c_data[3] = 64'h0080_0000_0000_4000;
    i_ch_cmd_data = {c_data[3], c_data[2], c_data[1], c_data[0]};

    repeat (3) tick();
    chk("rst_req", 64'(o_cmd_req), 64'(0));
    chk("rst_data", o_cmd_data, 64'(0));
    chk("rst_sel", 64'(o_ch_sel), 64'(0));
    chk("rst_cnt", 64'(o_cmd_cnt), 64'(0));
    chk("rst_to", 64'(o_timeout), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    // All four channels requesting: grants 0,1,2,3.
    i_ch_en = 4'hF;
    i_ch_cmd_req = 4'hF;
    txn(0, 1'b0, 10);
    txn(1, 1'b0, 10);
    txn(2, 1'b0, 10);
    txn(3, 1'b1, 10);
    chk("cnt_after_rr", 64'(o_cmd_cnt), 64'd4);

    // Single channel 2: one-cycle request latency and registered data.
    i_ch_cmd_req = 4'b0100;
    tick();
    chk("req_latency", 64'(o_cmd_req), 64'(1));
    chk("data_issue", o_cmd_data, 64'h0040_1234_5678_9ABC);
    txn(2, 1'b1, 10);
    chk("cnt_after_ch2", 64'(o_cmd_cnt), 64'd5);

    // Soft reset in ISSUE with a simultaneous ack: ack suppressed, request dropped.
    i_ch_cmd_req = 4'b0010;
    wait_req(ok);
    i_soft_rst = 1'b1;
    i_cmd_ack = 1'b1;
    #1;
    chk("srst_ack", 64'(o_ch_cmd_ack), 64'(0));
    tick();
    i_soft_rst = 1'b0;
    i_cmd_ack = 1'b0;
    i_ch_cmd_req = '0;
    chk("srst_req", 64'(o_cmd_req), 64'(0));
    chk("srst_sel", 64'(o_ch_sel), 64'(0));
    chk("srst_cnt", 64'(o_cmd_cnt), 64'd5);

    // Channel 2 disabled; ptr restarted at 0 by the soft reset: order 0,1,3,0.
    i_ch_en = 4'b1011;
    i_ch_cmd_req = 4'hF;
    txn(0, 1'b0, 10);
    txn(1, 1'b0, 10);
    txn(3, 1'b0, 10);
    txn(0, 1'b1, 10);
    chk("cnt_after_mask", 64'(o_cmd_cnt), 64'd9);
    i_ch_en = 4'hF;

    // Watchdog: no done, timeout on the 16th WAIT_DONE cycle (ptr=1 -> ch1).
    i_ch_cmd_req = 4'b0010;
    exp_to.push_back(1);
    ack_only(1);
    for (int n = 1; n <= 16; n++) begin
      chk("to_cycle", 64'(o_timeout), 64'(n == 16));
      if (n < 16) tick();
    end
    tick();
    chk("to_idle_req", 64'(o_cmd_req), 64'(0));
    chk("to_idle_sel", 64'(o_ch_sel), 64'(0));
    chk("to_cnt", 64'(o_cmd_cnt), 64'd10);

    // Done coincident with watchdog expiry counts as done (ptr=2 -> ch2).
    i_ch_cmd_req = 4'b0100;
    ack_only(2);
    repeat (15) tick();
    exp_done.push_back(4'b0100);
    i_done = 1'b1;
    #1;
    chk("same_to", 64'(o_timeout), 64'(0));
    chk("same_done", 64'(o_ch_done), 64'(4'b0100));
    tick();
    i_done = 1'b0;
    chk("same_sel_clr", 64'(o_ch_sel), 64'(0));

    // Ack and done while idle are ignored.
    i_done = 1'b1;
    i_cmd_ack = 1'b1;
    #1;
    chk("idle_done", 64'(o_ch_done), 64'(0));
    chk("idle_ack", 64'(o_ch_cmd_ack), 64'(0));
    tick();
    i_done = 1'b0;
    i_cmd_ack = 1'b0;
    chk("idle_req", 64'(o_cmd_req), 64'(0));
    chk("idle_cnt", 64'(o_cmd_cnt), 64'd11);

    // Enable dropped during WAIT_DONE: command completes normally (ptr=3 -> ch3).
    i_ch_cmd_req = 4'b1000;
    ack_only(3);
    i_ch_en = 4'b0111;
    chk("endrop_sel", 64'(o_ch_sel), 64'(4'b1000));
    repeat (4) tick();
    exp_done.push_back(4'b1000);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("endrop_clr", 64'(o_ch_sel), 64'(0));
    chk("endrop_cnt", 64'(o_cmd_cnt), 64'd12);
    i_ch_en = 4'hF;

    // Hard reset asserted in WAIT_DONE clears outputs without waiting for a clock.
    i_ch_cmd_req = 4'b0001;
    ack_only(0);
    repeat (3) tick();
    i_done = 1'b1;
    rst = 1'b0;
    #1;
    chk("hrst_req", 64'(o_cmd_req), 64'(0));
    chk("hrst_sel", 64'(o_ch_sel), 64'(0));
    chk("hrst_data", o_cmd_data, 64'(0));
    chk("hrst_cnt", 64'(o_cmd_cnt), 64'(0));
    chk("hrst_done", 64'(o_ch_done), 64'(0));
    chk("hrst_to", 64'(o_timeout), 64'(0));
    tick();
    i_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();

    chk("acc_queue_empty", 64'(exp_acc.size()), 64'(0));
    chk("done_queue_empty", 64'(exp_done.size()), 64'(0));
    chk("to_queue_empty", 64'(exp_to.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
